// File: rtl/fix_serializer.sv
// fix_serializer
// Turns a stream of field commands (binary tag + value bytes) into FIX
// "tag=value<SOH>" ASCII text and, on request, appends the "10=ccc<SOH>"
// checksum trailer.
//
// State  | meaning
// IDLE   | waiting for a field or trailer command (fld_ready_o high)
// CONV   | binary-to-BCD conversion of tag or checksum (double dabble)
// TAG    | emitting tag digits, most significant non-zero digit first
// SEP    | emitting '='
// VALUE  | forwarding value bytes until val_last_i
// SOH    | emitting the field-terminating SOH
// TRL    | emitting "10=", three checksum digits and SOH
// DROP   | illegal tag: swallowing value bytes through val_last_i
//
// Ports
//   clk, rst                         clock, async active-high reset
//   fld_valid_i/fld_ready_o          command handshake
//   fld_tag_i, fld_trailer_i         tag number / trailer request
//   val_valid_i/val_ready_o          value byte handshake
//   val_data_i, val_last_i           value byte and end-of-field marker
//   data_o, data_valid_o/data_ready_i serialized byte stream
//   tag_s_o, value_s_o, field_e_o, msg_e_o  per-byte qualifiers
//   tag_err_o                        sticky illegal-tag flag
module fix_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fld_valid_i,
  output logic        fld_ready_o,
  input  logic [13:0] fld_tag_i,
  input  logic        fld_trailer_i,
  input  logic        val_valid_i,
  output logic        val_ready_o,
  input  logic [7:0]  val_data_i,
  input  logic        val_last_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        tag_s_o,
  output logic        value_s_o,
  output logic        field_e_o,
  output logic        msg_e_o,
  output logic        tag_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_TAG, S_SEP, S_VALUE, S_SOH, S_TRL, S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic        run_q, is_trl_q, is_trl_d, err_q, err_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  dig_q, dig_d;
  logic [7:0]  csum_q, csum_d, csum_eff;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, trlb_q, trlb_d;
  logic        tag_s_q, tag_s_d, value_s_q, value_s_d;
  logic        field_e_q, field_e_d, msg_e_q, msg_e_d;

  logic        xfer, slot_free, fld_acc, val_acc;
  logic        load, ld_tag, ld_val, ld_fld, ld_msg, ld_trl;
  logic [7:0]  ld_data;
  logic [3:0]  tag_digit;
  logic [29:0] dd_next;

  // One double-dabble iteration on {bcd, bin}: adjust nibbles >= 5, shift.
  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  assign xfer        = valid_q & data_ready_i;
  assign slot_free   = ~valid_q | data_ready_i;
  assign fld_ready_o = run_q & (state_q == S_IDLE);
  assign val_ready_o = ((state_q == S_VALUE) & slot_free) | (state_q == S_DROP);
  assign fld_acc     = fld_valid_i & fld_ready_o;
  assign val_acc     = val_valid_i & val_ready_o;
  assign dd_next     = dd_step({bcd_q, bin_q});

  // Checksum as it will stand once the byte still sitting in the output
  // register has transferred; lets a trailer start without draining.
  always_comb begin
    csum_eff = csum_q;
    if (valid_q & msg_e_q)      csum_eff = 8'd0;
    else if (valid_q & ~trlb_q) csum_eff = csum_q + data_q;
  end

  always_comb begin
    tag_digit = bcd_q[3:0];
    case (dig_q[1:0])
      2'd1:    tag_digit = bcd_q[7:4];
      2'd2:    tag_digit = bcd_q[11:8];
      2'd3:    tag_digit = bcd_q[15:12];
      default: tag_digit = bcd_q[3:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    is_trl_d = is_trl_q;
    err_d    = err_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    load     = 1'b0;
    ld_data  = 8'h00;
    ld_tag   = 1'b0;
    ld_val   = 1'b0;
    ld_fld   = 1'b0;
    ld_msg   = 1'b0;
    ld_trl   = 1'b0;

    csum_d = csum_q;
    if (xfer) begin
      if (msg_e_q)      csum_d = 8'd0;
      else if (!trlb_q) csum_d = csum_q + data_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fld_acc) begin
          bcd_d = 16'd0;
          cnt_d = 4'd14;
          if (fld_trailer_i) begin
            is_trl_d = 1'b1;
            bin_d    = {6'd0, csum_eff};
            state_d  = S_CONV;
          end else if (fld_tag_i == 14'd0 || fld_tag_i > 14'd9999) begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            is_trl_d = 1'b0;
            bin_d    = fld_tag_i;
            state_d  = S_CONV;
          end
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = dd_next;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (is_trl_q) begin
            dig_d   = 3'd0;
            state_d = S_TRL;
          end else begin
            // Start at the most significant non-zero digit.
            if (dd_next[29:26] != 4'd0)      dig_d = 3'd3;
            else if (dd_next[25:22] != 4'd0) dig_d = 3'd2;
            else if (dd_next[21:18] != 4'd0) dig_d = 3'd1;
            else                             dig_d = 3'd0;
            state_d = S_TAG;
          end
        end
      end
      S_TAG: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = 8'h30 + {4'h0, tag_digit};
          ld_tag  = 1'b1;
          if (dig_q == 3'd0) state_d = S_SEP;
          else               dig_d   = dig_q - 3'd1;
        end
      end
      S_SEP: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = 8'h3D;
          ld_tag  = 1'b1;
          state_d = S_VALUE;
        end
      end
      S_VALUE: begin
        if (val_acc) begin
          load    = 1'b1;
          ld_data = val_data_i;
          ld_val  = 1'b1;
          if (val_last_i) state_d = S_SOH;
        end
      end
      S_SOH: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = 8'h01;
          ld_fld  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TRL: begin
        if (slot_free) begin
          load   = 1'b1;
          ld_trl = 1'b1;
          dig_d  = dig_q + 3'd1;
          case (dig_q)
            3'd0:    ld_data = 8'h31;
            3'd1:    ld_data = 8'h30;
            3'd2:    ld_data = 8'h3D;
            3'd3:    ld_data = 8'h30 + {4'h0, bcd_q[11:8]};
            3'd4:    ld_data = 8'h30 + {4'h0, bcd_q[7:4]};
            3'd5:    ld_data = 8'h30 + {4'h0, bcd_q[3:0]};
            default: begin
              ld_data = 8'h01;
              ld_msg  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_DROP: begin
        if (val_valid_i & val_last_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    data_d    = data_q;
    valid_d   = valid_q;
    tag_s_d   = tag_s_q;
    value_s_d = value_s_q;
    field_e_d = field_e_q;
    msg_e_d   = msg_e_q;
    trlb_d    = trlb_q;
    if (load) begin
      data_d    = ld_data;
      valid_d   = 1'b1;
      tag_s_d   = ld_tag;
      value_s_d = ld_val;
      field_e_d = ld_fld;
      msg_e_d   = ld_msg;
      trlb_d    = ld_trl;
    end else if (xfer) begin
      valid_d   = 1'b0;
      tag_s_d   = 1'b0;
      value_s_d = 1'b0;
      field_e_d = 1'b0;
      msg_e_d   = 1'b0;
      trlb_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      is_trl_q  <= 1'b0;
      err_q     <= 1'b0;
      bin_q     <= 14'd0;
      bcd_q     <= 16'd0;
      cnt_q     <= 4'd0;
      dig_q     <= 3'd0;
      csum_q    <= 8'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      trlb_q    <= 1'b0;
      tag_s_q   <= 1'b0;
      value_s_q <= 1'b0;
      field_e_q <= 1'b0;
      msg_e_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      is_trl_q  <= is_trl_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      csum_q    <= csum_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      trlb_q    <= trlb_d;
      tag_s_q   <= tag_s_d;
      value_s_q <= value_s_d;
      field_e_q <= field_e_d;
      msg_e_q   <= msg_e_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign tag_s_o      = tag_s_q;
  assign value_s_o    = value_s_q;
  assign field_e_o    = field_e_q;
  assign msg_e_o      = msg_e_q;
  assign tag_err_o    = err_q;

endmodule
